// File: rtl/rpn_tokenizer.sv
// ASCII RPN byte stream to PUSH/op command tokenizer for the queue calculator.
// Optional build macro RPN_OVERFLOW_CHECK_EN: saturate operands at 255 and flag error.
module rpn_tokenizer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cmd_apply,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_in,
  input  logic       cmd_ready,
  output logic       error,
  output logic       busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_NUM       = 2'd1;
  localparam logic [1:0] S_EMIT_PUSH = 2'd2;
  localparam logic [1:0] S_EMIT_OP   = 2'd3;

  localparam logic [2:0] OP_PUSH = 3'd1;

  logic [1:0] r_state;
  logic [7:0] r_acc;
  logic [2:0] r_op;
  logic       r_op_pending;
  logic       r_error;

  logic       w_accept;
  logic       w_is_digit;
  logic       w_is_sep;
  logic       w_is_op;
  logic [3:0] w_digit;
  logic [2:0] w_op_code;

`ifdef RPN_OVERFLOW_CHECK_EN
  logic [11:0] w_acc_calc;
  assign w_acc_calc = {4'd0, r_acc} * 12'd10 + {8'd0, w_digit};
`else
  // Low byte of the 12-bit acc*10+digit; only this byte survives the modulo-256 wrap.
  logic [7:0] w_acc_calc;
  assign w_acc_calc = r_acc * 8'd10 + {4'd0, w_digit};
`endif

  assign w_accept   = in_valid && in_ready;
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign w_digit    = in_data[3:0];
  assign w_is_sep   = (in_data == 8'h20) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign w_is_op    = (w_op_code != 3'd0);

  always_comb begin
    w_op_code = 3'd0;
    case (in_data)
      8'h2B:   w_op_code = 3'd2;
      8'h2D:   w_op_code = 3'd3;
      8'h2A:   w_op_code = 3'd4;
      8'h2F:   w_op_code = 3'd5;
      8'h25:   w_op_code = 3'd6;
      default: w_op_code = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= 8'd0;
      r_op         <= 3'd0;
      r_op_pending <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_digit) begin
              r_acc   <= {4'd0, w_digit};
              r_state <= S_NUM;
            end else if (w_is_op) begin
              r_op    <= w_op_code;
              r_state <= S_EMIT_OP;
            end else if (!w_is_sep) begin
              r_error <= 1'b1;
            end
          end
        end
        S_NUM: begin
          if (w_accept) begin
            if (w_is_digit) begin
`ifdef RPN_OVERFLOW_CHECK_EN
              if (w_acc_calc > 12'd255) begin
                r_acc   <= 8'd255;
                r_error <= 1'b1;
              end else begin
                r_acc <= w_acc_calc[7:0];
              end
`else
              r_acc <= w_acc_calc;
`endif
            end else if (w_is_sep) begin
              r_state <= S_EMIT_PUSH;
            end else if (w_is_op) begin
              r_op         <= w_op_code;
              r_op_pending <= 1'b1;
              r_state      <= S_EMIT_PUSH;
            end else begin
              // Malformed token: drop the partial number entirely.
              r_error <= 1'b1;
              r_acc   <= 8'd0;
              r_state <= S_IDLE;
            end
          end
        end
        S_EMIT_PUSH: begin
          if (cmd_ready) begin
            r_state <= r_op_pending ? S_EMIT_OP : S_IDLE;
          end
        end
        default: begin
          if (cmd_ready) begin
            r_op_pending <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Command outputs decode straight from registered state, so they stay stable while held.
  assign cmd_apply = (r_state == S_EMIT_PUSH) || (r_state == S_EMIT_OP);
  assign cmd_op    = (r_state == S_EMIT_PUSH) ? OP_PUSH :
                     (r_state == S_EMIT_OP)   ? r_op    : 3'd0;
  assign cmd_in    = (r_state == S_EMIT_PUSH) ? r_acc : 8'd0;
  assign in_ready  = !cmd_apply && !r_op_pending;
  assign busy      = (r_state != S_IDLE);
  assign error     = r_error;

endmodule

// File: doc/rpn_tokenizer.md
RPN_TOKENIZER -- requirements
Module: rpn_tokenizer

Purpose: turns an ASCII RPN text byte stream into apply/op/operand commands for the queue calculator.

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_data, input, 8, ASCII character.
REQ-004 SHALL have port in_valid, input, 1, in_data is valid.
REQ-005 SHALL have port in_ready, output, 1, tokenizer accepts in_data this cycle.
REQ-006 SHALL have port cmd_apply, output, 1, command valid, held until accepted.
REQ-007 SHALL have port cmd_op, output, 3, op code: 1 PUSH, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 MOD.
REQ-008 SHALL have port cmd_in, output, 8, operand for PUSH, 0 otherwise.
REQ-009 SHALL have port cmd_ready, input, 1, calculator accepts the command; tie high for a calculator without backpressure.
REQ-010 SHALL have port error, output, 1, sticky syntax/overflow flag.
REQ-011 SHALL have port busy, output, 1, high when a number is pending or a command is queued.

Function
REQ-012 SHALL accept a byte only on a clk edge with in_valid and in_ready both high.
REQ-013 SHALL drive in_ready = !cmd_apply && !op_pending.
REQ-014 SHALL have FSM states IDLE, NUM, EMIT_PUSH and EMIT_OP.
REQ-015 SHALL, on an accepted digit '0'-'9' in IDLE, load acc = digit and go to NUM.
REQ-016 SHALL, on a digit in NUM, set acc = acc*10 + digit, computed at 12-bit width.
REQ-017 SHALL treat space (0x20), LF (0x0A) and CR (0x0D) as separators: in NUM they go to EMIT_PUSH; in IDLE they are ignored.
REQ-018 SHALL map operators '+','-','*','/','%' to ops 2,3,4,5,6 respectively.
REQ-019 SHALL, on an operator in IDLE, go to EMIT_OP with the op latched.
REQ-020 SHALL, on an operator in NUM, go to EMIT_PUSH, latch the op and set op_pending.
REQ-021 SHALL, in EMIT_PUSH, assert cmd_apply=1, cmd_op=1 and cmd_in=acc[7:0] from the cycle after acceptance; on cmd_ready go to EMIT_OP if op_pending, else IDLE.
REQ-022 SHALL, in EMIT_OP, assert cmd_apply=1, cmd_op=latched op and cmd_in=0; on cmd_ready clear op_pending and go to IDLE.
REQ-023 SHALL keep cmd_op and cmd_in stable while cmd_apply=1 and cmd_ready=0.
REQ-024 SHALL issue exactly one command per cmd_apply&&cmd_ready cycle.
REQ-025 SHALL give a minimum latency of 1 cycle from the accepting edge to cmd_apply; an operator after a digit yields PUSH then op on consecutive cycles when cmd_ready=1.
REQ-026 SHALL, on any other character, set error and drop the character; in NUM the pending number is discarded and the FSM returns to IDLE.
REQ-027 SHALL deassert in_ready during EMIT states, so no byte is lost under backpressure.

Reset
REQ-028 SHALL, on rst, asynchronously clear state to IDLE, and set acc, op_pending, cmd_apply, cmd_op, cmd_in, error and busy to 0 and in_ready to 1.
REQ-029 SHALL, on rst during EMIT, abandon the pending command with no apply afterwards.
REQ-030 SHALL clear error only by rst.

Configuration
REQ-031 SHALL, with RPN_OVERFLOW_CHECK_EN defined, saturate acc at 255 when it exceeds 255 and set error; the PUSH is still issued with 255.
REQ-032 SHALL, without RPN_OVERFLOW_CHECK_EN, keep acc modulo 256 (wrap) and never set error on overflow.

Verification
REQ-033 SHALL pass: "12 3+\n" with cmd_ready=1 -> PUSH 12, PUSH 3, ADD(2); error=0.
REQ-034 SHALL pass: "7 2%" with cmd_ready low for 3 cycles at each command -> same PUSH 7, PUSH 2, MOD sequence, stable outputs, in_ready=0 while held.
REQ-035 SHALL pass: "300 " -> with macro PUSH 255 and error=1; without macro PUSH 44 and error=0.
REQ-036 SHALL pass: "5a6 " -> error=1 and 5 discarded; "6 " then gives PUSH 6.
REQ-037 SHALL pass: rst asserted while in EMIT_OP after "4 9*" -> no MUL issued, all outputs at reset values, in_ready=1.
REQ-038 SHALL pass: "  -" in IDLE -> single SUB(3), no PUSH.
